// File: rtl/uart_rx.sv
// UART receiver: oversampled 8N1 deserializer with framing-error detection.
// Define UART_RX_PARITY_EN to add a parity bit check and the parity_err port.
module uart_rx #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_ODD = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 frame_err,
  output logic                 busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 parity_err
`endif
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    PARITY,
`endif
    STOP,
    BREAK
  } state_t;

  state_t               state, state_n;
  logic                 rx_meta, rx_s;
  logic [TW-1:0]        tick_cnt, tick_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n, rx_data_n;
  logic                 rx_valid_n, frame_err_n;
`ifdef UART_RX_PARITY_EN
  localparam logic PAR_SENSE = logic'(PARITY_ODD != 0);
  logic par_bad, par_bad_n, parity_err_n;
`endif

  assign busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta   <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      tick_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      rx_meta   <= rx;
      rx_s      <= rx_meta;
      state     <= state_n;
      tick_cnt  <= tick_cnt_n;
      bit_cnt   <= bit_cnt_n;
      shift     <= shift_n;
      rx_data   <= rx_data_n;
      rx_valid  <= rx_valid_n;
      frame_err <= frame_err_n;
`ifdef UART_RX_PARITY_EN
      par_bad    <= par_bad_n;
      parity_err <= parity_err_n;
`endif
    end
  end

  always_comb begin
    state_n     = state;
    tick_cnt_n  = tick_cnt;
    bit_cnt_n   = bit_cnt;
    shift_n     = shift;
    rx_data_n   = rx_data;
    rx_valid_n  = 1'b0;
    frame_err_n = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_bad_n    = par_bad;
    parity_err_n = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (!rx_s) begin
          state_n    = START;
          tick_cnt_n = '0;
        end
      end
      // A start bit must still be low at its midpoint, otherwise it was a glitch.
      START: begin
        if (tick) begin
          if (tick_cnt == TICK_MID) begin
            if (!rx_s) begin
              state_n    = DATA;
              tick_cnt_n = '0;
              bit_cnt_n  = '0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      DATA: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            shift_n    = {rx_s, shift[DATA_BITS-1:1]};
            bit_cnt_n  = bit_cnt + 1'b1;
            if (bit_cnt == BIT_LAST) begin
`ifdef UART_RX_PARITY_EN
              state_n = PARITY;
`else
              state_n = STOP;
`endif
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            tick_cnt_n = '0;
            par_bad_n  = (rx_s != ((^shift) ^ PAR_SENSE));
            state_n    = STOP;
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
`endif
      // Framing error outranks parity error; a bad frame never updates rx_data.
      STOP: begin
        if (tick) begin
          if (tick_cnt == TICK_LAST) begin
            if (rx_s) begin
              state_n = IDLE;
`ifdef UART_RX_PARITY_EN
              if (par_bad) begin
                parity_err_n = 1'b1;
              end else begin
                rx_data_n  = shift;
                rx_valid_n = 1'b1;
              end
`else
              rx_data_n  = shift;
              rx_valid_n = 1'b1;
`endif
            end else begin
              frame_err_n = 1'b1;
              state_n     = BREAK;
            end
          end else begin
            tick_cnt_n = tick_cnt + 1'b1;
          end
        end
      end
      BREAK: begin
        if (rx_s) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed self-checking bench for uart_rx: normal frames, glitch, break,
// mid-frame reset, parity (when UART_RX_PARITY_EN is defined) and tick tied high.
module tb_uart_rx;

  localparam int DATA_BITS  = 8;
  localparam int OVERSAMPLE = 16;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 tick = 1'b0;
  logic                 rx = 1'b1;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 frame_err;
  logic                 busy;
`ifdef UART_RX_PARITY_EN
  logic                 parity_err;
`endif

  int errors = 0;
  int checks = 0;
  int valid_cnt = 0;
  int ferr_cnt = 0;
  int perr_cnt = 0;
  int cyc = 0;
  int valid_cyc = 0;
  int start_cyc = 0;
  int div = 0;
  bit tick_all = 1'b0;

  uart_rx #(
    .DATA_BITS (DATA_BITS),
    .OVERSAMPLE(OVERSAMPLE),
    .PARITY_ODD(0)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .rx       (rx),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .frame_err(frame_err),
    .busy     (busy)
`ifdef UART_RX_PARITY_EN
    ,
    .parity_err(parity_err)
`endif
  );

  always #25 clk = ~clk;

  always @(posedge clk) cyc++;

  // One tick every 4 clk, or every clk when tick_all is set.
  always @(negedge clk) begin
    if (tick_all) begin
      tick = 1'b1;
    end else begin
      tick = (div == 3);
      div  = (div + 1) % 4;
    end
  end

  // Counts high cycles, so a pulse wider than one clk shows up as an extra count.
  always @(negedge clk) begin
    if (rx_valid) begin
      valid_cnt++;
      valid_cyc = cyc;
    end
    if (frame_err) ferr_cnt++;
`ifdef UART_RX_PARITY_EN
    if (parity_err) perr_cnt++;
`endif
  end

  task automatic driveBit(input logic val);
    rx = val;
    repeat (tick_all ? OVERSAMPLE : OVERSAMPLE * 4) @(negedge clk);
  endtask

  task automatic applyStimulus(input logic [7:0] data, input logic stop_val);
    start_cyc = cyc;
    driveBit(1'b0);
    for (int i = 0; i < 8; i++) driveBit(data[i]);
`ifdef UART_RX_PARITY_EN
    driveBit(^data);
`endif
    driveBit(stop_val);
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  initial begin
    #(50 * 60000);
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("reset_busy", 32'(busy), 32'd0);
    checkOutput("reset_data", 32'(rx_data), 32'h00);
    checkOutput("reset_valid", 32'(rx_valid), 32'd0);
    checkOutput("reset_ferr", 32'(frame_err), 32'd0);
    rst = 1'b0;
    repeat (64) @(negedge clk);

    $display("[TB] back-to-back frames 0x55, 0xA3");
    applyStimulus(8'h55, 1'b1);
    checkOutput("b2b_data0", 32'(rx_data), 32'h55);
    checkOutput("b2b_valid0", 32'(valid_cnt), 32'd1);
    applyStimulus(8'hA3, 1'b1);
    checkOutput("b2b_data1", 32'(rx_data), 32'hA3);
    checkOutput("b2b_valid1", 32'(valid_cnt), 32'd2);
    checkOutput("b2b_ferr", 32'(ferr_cnt), 32'd0);
    repeat (64) @(negedge clk);

    $display("[TB] start-bit glitch");
    rx = 1'b0;
    repeat (16) @(negedge clk);
    rx = 1'b1;
    for (int i = 0; i < 32; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    checkOutput("glitch_busy", 32'(busy), 32'd0);
    repeat (64) @(negedge clk);
    checkOutput("glitch_valid", 32'(valid_cnt), 32'd2);
    checkOutput("glitch_ferr", 32'(ferr_cnt), 32'd0);

    $display("[TB] framing error and break");
    applyStimulus(8'h3C, 1'b0);
    repeat (3) driveBit(1'b0);
    driveBit(1'b1);
    checkOutput("break_ferr", 32'(ferr_cnt), 32'd1);
    checkOutput("break_data", 32'(rx_data), 32'hA3);
    checkOutput("break_valid", 32'(valid_cnt), 32'd2);
    applyStimulus(8'h81, 1'b1);
    checkOutput("after_break_data", 32'(rx_data), 32'h81);
    checkOutput("after_break_valid", 32'(valid_cnt), 32'd3);
    repeat (64) @(negedge clk);

    $display("[TB] reset during data bit 4 of 0xFF");
    driveBit(1'b0);
    for (int i = 0; i < 4; i++) driveBit(1'b1);
    rx = 1'b1;
    repeat (32) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("midreset_busy", 32'(busy), 32'd0);
    checkOutput("midreset_data", 32'(rx_data), 32'h00);
    repeat (256) @(negedge clk);
    checkOutput("midreset_valid", 32'(valid_cnt), 32'd3);
    checkOutput("midreset_ferr", 32'(ferr_cnt), 32'd1);
    applyStimulus(8'h12, 1'b1);
    checkOutput("post_reset_data", 32'(rx_data), 32'h12);
    checkOutput("post_reset_valid", 32'(valid_cnt), 32'd4);
    repeat (64) @(negedge clk);

`ifdef UART_RX_PARITY_EN
    $display("[TB] parity good then bad");
    applyStimulus(8'h07, 1'b1);
    checkOutput("par_good_data", 32'(rx_data), 32'h07);
    checkOutput("par_good_valid", 32'(valid_cnt), 32'd5);
    checkOutput("par_good_perr", 32'(perr_cnt), 32'd0);
    driveBit(1'b0);
    for (int i = 0; i < 3; i++) driveBit(1'b1);
    for (int i = 0; i < 5; i++) driveBit(1'b0);
    driveBit(1'b0);
    driveBit(1'b1);
    checkOutput("par_bad_perr", 32'(perr_cnt), 32'd1);
    checkOutput("par_bad_valid", 32'(valid_cnt), 32'd5);
    checkOutput("par_bad_ferr", 32'(ferr_cnt), 32'd1);
    repeat (64) @(negedge clk);
`endif

    $display("[TB] tick tied high, frame 0xC9");
    tick_all = 1'b1;
    repeat (16) @(negedge clk);
    begin
      int base_valid;
      base_valid = valid_cnt;
      applyStimulus(8'hC9, 1'b1);
      repeat (16) @(negedge clk);
      checkOutput("fast_data", 32'(rx_data), 32'hC9);
      checkOutput("fast_valid", 32'(valid_cnt - base_valid), 32'd1);
`ifdef UART_RX_PARITY_EN
      checkOutput("fast_latency", 32'(valid_cyc - start_cyc), 32'd171);
`else
      checkOutput("fast_latency", 32'(valid_cyc - start_cyc), 32'd155);
`endif
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
